// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with double-buffered image.
// Define SEG_DRV_HEX_EN to decode codes 10-15 as A,b,C,d,E,F (blank otherwise).
//
//   state | meaning
//   OFF   | scan disabled, outputs zero, counter/index at 0
//   GUARD | anti-ghosting blank at slot start, commons off
//   SHOW  | one digit common driven with its decoded segments
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int GUARD_CYC  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_load,
    input  logic [4*NUM_DIGITS-1:0]   i_bcd,
    input  logic [NUM_DIGITS-1:0]     i_dot,
    input  logic                      i_blank_lz,
    output logic [7:0]                o_seg_data,
    output logic [NUM_DIGITS-1:0]     o_digit_sel,
    output logic                      o_frame_done,
    output logic                      o_load_pend
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_OFF, ST_GUARD, ST_SHOW} state_t;

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]          r_idx, w_idx_nxt;
    logic [4*NUM_DIGITS-1:0]   r_pend_bcd, r_act_bcd, w_act_bcd_nxt;
    logic [NUM_DIGITS-1:0]     r_pend_dot, r_act_dot, w_act_dot_nxt;
    logic                      w_wrap, w_commit, w_run;
    logic [NUM_DIGITS-1:0]     w_lz;
    logic [3:0]                w_code;
    logic [7:0]                w_seg_nxt;
    logic [NUM_DIGITS-1:0]     w_sel_nxt;

    function automatic logic [6:0] dec7(input logic [3:0] c);
        case (c)
            4'h0:    dec7 = 7'b1111110;
            4'h1:    dec7 = 7'b0110000;
            4'h2:    dec7 = 7'b1101101;
            4'h3:    dec7 = 7'b1111001;
            4'h4:    dec7 = 7'b0110011;
            4'h5:    dec7 = 7'b1011011;
            4'h6:    dec7 = 7'b1011111;
            4'h7:    dec7 = 7'b1110000;
            4'h8:    dec7 = 7'b1111111;
            4'h9:    dec7 = 7'b1111011;
`ifdef SEG_DRV_HEX_EN
            4'hA:    dec7 = 7'b1110111;
            4'hB:    dec7 = 7'b0011111;
            4'hC:    dec7 = 7'b1001110;
            4'hD:    dec7 = 7'b0111101;
            4'hE:    dec7 = 7'b1001111;
            4'hF:    dec7 = 7'b1000111;
`endif
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        if (!i_enable) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = (GUARD_CYC == 0) ? ST_SHOW : ST_GUARD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                ST_GUARD: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == GUARD_LAST) w_state_nxt = ST_SHOW;
                end
                ST_SHOW: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (GUARD_CYC == 0) ? ST_SHOW : ST_GUARD;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt = '0;
                            w_wrap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    // Outputs are registered from the next-cycle image so they line up with the state.
    assign w_commit      = w_wrap & o_load_pend;
    assign w_act_bcd_nxt = w_commit ? r_pend_bcd : r_act_bcd;
    assign w_act_dot_nxt = w_commit ? r_pend_dot : r_act_dot;

    always_comb begin
        w_lz  = '0;
        w_run = i_blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run   = w_run & (w_act_bcd_nxt[4*i +: 4] == 4'd0);
            w_lz[i] = w_run;
        end
    end

    always_comb begin
        w_code    = w_act_bcd_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_seg_nxt = '0;
        w_sel_nxt = '0;
        if (w_state_nxt == ST_SHOW) begin
            w_seg_nxt = {dec7(w_code) & ~{7{w_lz[w_idx_nxt]}}, w_act_dot_nxt[w_idx_nxt]};
            w_sel_nxt = NUM_DIGITS'(1) << w_idx_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend_bcd   <= '0;
            r_pend_dot   <= '0;
            r_act_bcd    <= '0;
            r_act_dot    <= '0;
            o_seg_data   <= '0;
            o_digit_sel  <= '0;
            o_frame_done <= 1'b0;
            o_load_pend  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_act_bcd    <= w_act_bcd_nxt;
            r_act_dot    <= w_act_dot_nxt;
            o_seg_data   <= w_seg_nxt;
            o_digit_sel  <= w_sel_nxt;
            o_frame_done <= w_wrap;
            // A load on the commit cycle refills pending after the old data moved out.
            o_load_pend  <= i_load | (o_load_pend & ~w_commit);
            if (i_load) begin
                r_pend_bcd <= i_bcd;
                r_pend_dot <= i_dot;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (N=4, TICK_DIV=4, GUARD_CYC=1).
// Build with SEG_DRV_HEX_EN defined to match a hex-enabled design.
module tb_seg_scan_driver;

    localparam int N = 4;
    localparam int T = 4;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd = '0;
    logic [3:0]  dot = '0;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        fd;
    logic        pend;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];

    seg_scan_driver #(.NUM_DIGITS(N), .TICK_DIV(T), .GUARD_CYC(G)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_load(load),
        .i_bcd(bcd), .i_dot(dot), .i_blank_lz(blank_lz),
        .o_seg_data(seg), .o_digit_sel(sel), .o_frame_done(fd), .o_load_pend(pend)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [16];
    initial begin
        segtab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                   7'b1111111, 7'b1111011,
`ifdef SEG_DRV_HEX_EN
                   7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
`else
                   7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0
`endif
                  };
    end

    // Reference: position in the scan is derived from cycles since enable.
    bit          m_on = 0;
    int          m_t = 0;
    logic [15:0] m_act = '0, m_pend = '0;
    logic [3:0]  m_actdot = '0, m_penddot = '0;
    bit          m_pf = 0;

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   wrap;
        int   d;
        if (!rst_n) begin
            m_on = 0; m_t = 0; m_act = '0; m_pend = '0;
            m_actdot = '0; m_penddot = '0; m_pf = 0;
            exp_q.delete();
        end else begin
            wrap = 0;
            if (!enable) begin
                m_on = 0; m_t = 0;
            end else begin
                if (!m_on) begin m_on = 1; m_t = 0; end
                else m_t++;
                wrap = (m_t > 0) && (m_t % (N*T) == 0);
            end
            if (wrap && m_pf) begin
                m_act = m_pend; m_actdot = m_penddot; m_pf = 0;
            end
            if (load) begin
                m_pend = bcd; m_penddot = dot; m_pf = 1;
            end
            e = '0;
            e.fd = wrap;
            e.pend = m_pf;
            if (m_on && (m_t % T) >= G) begin
                d = (m_t / T) % N;
                e.sel = 4'(1 << d);
                if (blank_lz && d != 0 && (m_act >> (4*d)) == 16'h0)
                    e.seg = {7'b0, m_actdot[d]};
                else
                    e.seg = {segtab[(m_act >> (4*d)) & 16'hF], m_actdot[d]};
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if ({seg, sel, fd, pend} !== '0) begin
                failures++;
                $display("FAIL rst_outs actual=%b_%b_%b_%b required=0", seg, sel, fd, pend);
            end
        end else if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty actual=no_expectation required=one_per_cycle t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({seg, sel, fd, pend} !== e) begin
                failures++;
                $display("FAIL sb_cycle t=%0t actual seg=%b sel=%b fd=%b pend=%b required seg=%b sel=%b fd=%b pend=%b",
                         $time, seg, sel, fd, pend, e.seg, e.sel, e.fd, e.pend);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_digit(input string name, input logic [3:0] s, input logic [7:0] v);
        bit found = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (sel == s) begin found = 1; break; end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=sel_never_seen required=sel_%b", name, s);
        end else begin
            check(name, seg, v);
        end
    endtask

    task automatic wait_frame(input string name);
        bit found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fd) begin found = 1; break; end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_frame_done required=frame_done", name);
        end
    endtask

    task automatic wait_show(input string name);
        bit found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel != 4'b0) begin found = 1; break; end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_show required=show", name);
        end
    endtask

    task automatic pulse_load(input logic [15:0] b, input logic [3:0] d);
        bcd = b; dot = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {seg, sel, fd, pend}, 0);

        enable = 1'b1;
        expect_digit("zeros_d0", 4'b0001, 8'b11111100);
        expect_digit("zeros_d3", 4'b1000, 8'b11111100);

        pulse_load(16'h1234, 4'b0010);
        check("pend_after_load", pend, 1);
        wait_frame("commit_1234");
        expect_digit("d0_4",    4'b0001, 8'b01100110);
        expect_digit("d1_3dp",  4'b0010, 8'b11110011);
        expect_digit("d2_2",    4'b0100, 8'b11011010);
        expect_digit("d3_1",    4'b1000, 8'b01100000);

        blank_lz = 1'b1;
        pulse_load(16'h0070, 4'b0000);
        wait_frame("commit_0070");
        expect_digit("lz_d0", 4'b0001, 8'b11111100);
        expect_digit("lz_d1", 4'b0010, 8'b11100000);
        expect_digit("lz_d2", 4'b0100, 8'b00000000);
        expect_digit("lz_d3", 4'b1000, 8'b00000000);
        blank_lz = 1'b0;
        expect_digit("nolz_d3", 4'b1000, 8'b11111100);

        // Load lands exactly on the wrap edge while pending already holds data.
        wait_frame("pre_wrap");
        pulse_load(16'h5678, 4'b0000);
        repeat (14) @(negedge clk);
        bcd = 16'h4321; dot = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("wrap_fd", fd, 1);
        check("wrap_pend_kept", pend, 1);
        expect_digit("wrap_old_d0", 4'b0001, 8'b11111110);
        wait_frame("wrap_next");
        expect_digit("wrap_new_d0", 4'b0001, 8'b01100000);

        blank_lz = 1'b1;
        pulse_load(16'h000B, 4'b0000);
        wait_frame("commit_hex");
`ifdef SEG_DRV_HEX_EN
        expect_digit("hex_b", 4'b0001, 8'b00111110);
`else
        expect_digit("hex_b", 4'b0001, 8'b00000000);
`endif

        for (int it = 0; it < 40; it++) begin
            blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) pulse_load(16'($urandom), 4'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                enable = 1'b1;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        wait_show("drop_show");
        enable = 1'b0;
        @(negedge clk);
        check("drop_outs_zero", {seg, sel, fd}, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reen_guard", sel, 4'b0000);
        @(negedge clk);
        check("reen_d0", sel, 4'b0001);

        wait_show("rst_show");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_outs", {seg, sel, fd, pend}, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("post_rst_guard", sel, 4'b0000);
        @(negedge clk);
        check("post_rst_d0", {seg, sel}, {8'b11111100, 4'b0001});
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
